// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if
// Bundles the three ports of the video RAM arbiter into one interface:
//   - the VGA scan-out read port: vga_video_on, vga_rd_req, vga_rd_addr,
//     vga_rd_data, vga_rd_valid
//   - the RTC writer port: wr_req, wr_addr, wr_data, wr_ack, wr_full
//   - the single-port RAM port: mem_addr, mem_we, mem_wdata, mem_rdata
// Modports:
//   - master: the surroundings of the arbiter (VGA controller, writer, RAM).
//   - slave: the arbiter itself.
interface vga_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);

  // Scan-out read port
  logic              vga_video_on;
  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;

  // Display-update writer port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_full;

  // Block RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output vga_video_on, vga_rd_req, vga_rd_addr,
    output wr_req, wr_addr, wr_data,
    output mem_rdata,
    input  vga_rd_data, vga_rd_valid,
    input  wr_ack, wr_full,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  vga_video_on, vga_rd_req, vga_rd_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_rdata,
    output vga_rd_data, vga_rd_valid,
    output wr_ack, wr_full,
    output mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter
// Shares the single-port video RAM between VGA scan-out reads and RTC
// display-update writes. Scan-out reads always win the RAM. Writes are
// buffered in a small FIFO and are retired only in cycles where no read is
// requested, normally during blanking.
// Ports:
//   clk - system clock (50 MHz)
//   rst - asynchronous, active-low reset
//   bus - vga_vram_arbiter_if.slave:
//     vga_video_on, vga_rd_req, vga_rd_addr -> vga_rd_data, vga_rd_valid
//       (read data two clocks after the request is sampled)
//     wr_req, wr_addr, wr_data -> wr_ack (cycle after acceptance), wr_full
//     mem_addr, mem_we, mem_wdata (registered) / mem_rdata (sync RAM)
// Build option:
//   VRAM_ARB_STARVE_GUARD_EN - when defined, a full write queue may also
//   retire into idle cycles of active video, which bounds writer stall.
//   When undefined, writes retire only while vga_video_on is low.
module vga_vram_arbiter #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WQ_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  vga_vram_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  wq_entry_t         wq_mem [WQ_DEPTH];
  wq_entry_t         head_c;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push_c;
  logic              pop_c;
  logic              wr_window_c;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_we_q;
  logic              mem_we_d;

  logic              wr_full_q;
  logic              wr_ack_q;
  logic              rd_inflight_q;
  logic              vga_rd_valid_q;
  logic [DATA_W-1:0] vga_rd_data_q;

  // Queue head feeds the RAM port directly when a write is granted.
  assign head_c = wq_mem[rd_ptr_q];

  // Cycles in which a queued write may use the RAM (reads still take priority).
  always_comb begin
    wr_window_c = !bus.vga_video_on;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    if (wr_full_q) begin
      wr_window_c = 1'b1;
    end
`else
    wr_window_c = wr_window_c;
`endif
  end

  // Per-cycle grant: next state and the RAM port values that go with it.
  always_comb begin
    state_d     = IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (bus.vga_rd_req) begin
      state_d    = RD;
      mem_addr_d = bus.vga_rd_addr;
    end else if ((count_q != '0) && wr_window_c) begin
      state_d     = WR;
      mem_addr_d  = head_c.addr;
      mem_wdata_d = head_c.data;
      mem_we_d    = 1'b1;
    end
  end

  // Full is judged on the registered count, so a same-cycle pop cannot
  // open a slot for a push.
  assign push_c  = bus.wr_req && !wr_full_q;
  assign pop_c   = (state_d == WR);
  assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

  // Grant state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write queue storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_c) begin
      wq_mem[wr_ptr_q] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end
  end

  // Write queue pointers, occupancy and writer handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_full_q <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q   <= count_d;
      wr_full_q <= (count_d == FULL_CNT);
      wr_ack_q  <= push_c;
    end
  end

  // RAM port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Read return: address goes out in the RD cycle, the RAM samples it on the
  // next edge, and its output is captured one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_inflight_q  <= 1'b0;
      vga_rd_valid_q <= 1'b0;
      vga_rd_data_q  <= '0;
    end else begin
      rd_inflight_q  <= (state_q == RD);
      vga_rd_valid_q <= rd_inflight_q;
      if (rd_inflight_q) begin
        vga_rd_data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.vga_rd_data  = vga_rd_data_q;
  assign bus.vga_rd_valid = vga_rd_valid_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_full      = wr_full_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter
// Scoreboard bench for vga_vram_arbiter: stimulus pushes expected reads
// (data plus arrival cycle) and expected RAM writes into queues; a monitor on
// the falling clock edge pops and compares whenever vga_rd_valid or mem_we is
// seen. Point checks raised by the stimulus are queued to the same monitor.
module tb_vga_vram_arbiter;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WQ_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  vga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_vram_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WQ_DEPTH(WQ_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Synchronous single-port RAM model.
  logic [7:0] ram [2048];
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
    ram[11'h123] <= 8'h5A;
    ram[11'h040] <= 8'h11;
  end
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Scoreboard state
  typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
  typedef struct { string name; int act; int exp; } chk_t;
  rd_exp_t      rd_exp_q [$];
  logic [18:0]  wr_exp_q [$];
  chk_t         chk_q    [$];

  int n_tests   = 0;
  int n_fails   = 0;
  int we_count  = 0;
  int we_last   = -10;
  int we_run    = 0;
  int ack_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_q.push_back('{name: name, act: act, exp: exp});
  endtask

  task automatic compare(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes point checks and compares every DUT read/write event.
  always @(negedge clk) begin
    chk_t        c;
    rd_exp_t     r;
    logic [18:0] w;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
    if (rst) begin
      if (bus.vga_rd_valid) begin
        if (rd_exp_q.size() == 0) begin
          compare("rd_unexpected_valid", 1, 0);
        end else begin
          r = rd_exp_q.pop_front();
          compare("rd_data", int'(bus.vga_rd_data), int'(r.data));
          compare("rd_latency_cycle", cyc, r.cyc);
        end
      end
      if (bus.mem_we) begin
        if (wr_exp_q.size() == 0) begin
          compare("wr_unexpected_we", 1, 0);
        end else begin
          w = wr_exp_q.pop_front();
          compare("wr_addr", int'(bus.mem_addr), int'(w[18:8]));
          compare("wr_data", int'(bus.mem_wdata), int'(w[7:0]));
        end
        we_run   = (we_last == cyc - 1) ? we_run + 1 : 1;
        we_last  = cyc;
        we_count = we_count + 1;
      end
      if (bus.wr_ack) ack_count = ack_count + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read request held for exactly one edge; data due three falling edges on.
  task automatic do_read(input logic [10:0] a, input logic [7:0] d);
    bus.vga_rd_req  = 1'b1;
    bus.vga_rd_addr = a;
    rd_exp_q.push_back('{data: d, cyc: cyc + 3});
    @(negedge clk);
    bus.vga_rd_req = 1'b0;
  endtask

  // Writer holds its request until acknowledged (bounded wait).
  task automatic do_write(input logic [10:0] a, input logic [7:0] d, input bit expect_mem);
    int got;
    got = 0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (expect_mem) wr_exp_q.push_back({a, d});
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1;
    end
    bus.wr_req = 1'b0;
    chk("wr_ack_seen", got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vga_rd_data"},  int'(bus.vga_rd_data),  0);
    chk({tag, "_vga_rd_valid"}, int'(bus.vga_rd_valid), 0);
    chk({tag, "_wr_ack"},       int'(bus.wr_ack),       0);
    chk({tag, "_wr_full"},      int'(bus.wr_full),      0);
    chk({tag, "_mem_addr"},     int'(bus.mem_addr),     0);
    chk({tag, "_mem_we"},       int'(bus.mem_we),       0);
    chk({tag, "_mem_wdata"},    int'(bus.mem_wdata),    0);
  endtask

  initial begin
    int a0;
    int w0;
    int n_ack;
    int n_we;
    int got;

    rst              = 1'b0;
    bus.vga_video_on = 1'b0;
    bus.vga_rd_req   = 1'b0;
    bus.vga_rd_addr  = '0;
    bus.wr_req       = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;

    idle(3);
    check_reset_outputs("rst_init");
    rst = 1'b1;
    idle(2);

    // Read latency: single read, then eight back-to-back reads.
    bus.vga_video_on = 1'b1;
    do_read(11'h123, 8'h5A);
    idle(4);
    for (int i = 0; i < 8; i++) do_read(11'(11'h200 + i), init_val(11'h200 + i));
    idle(4);

    // Blanking drain: four writes retire on four consecutive clocks.
    bus.vga_video_on = 1'b0;
    a0 = ack_count;
    w0 = we_count;
    for (int i = 0; i < 4; i++) do_write(11'(11'h010 + i), 8'(8'hA0 + i), 1'b1);
    idle(6);
    chk("drain_acks", ack_count - a0, 4);
    chk("drain_we_count", we_count - w0, 4);
    chk("drain_consecutive", we_run, 4);

    // Priority: queued writes only use gaps between alternating reads.
    bus.vga_video_on = 1'b1;
    w0 = we_count;
    for (int i = 0; i < 4; i++) do_write(11'(11'h020 + i), 8'(8'hB0 + i), 1'b1);
    bus.vga_video_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read(11'(11'h300 + i), init_val(11'h300 + i));
      @(negedge clk);
    end
    idle(8);
    chk("prio_we_count", we_count - w0, 4);

    // Full queue in active video.
    bus.vga_video_on = 1'b1;
    w0 = we_count;
    for (int i = 0; i < 4; i++) do_write(11'(11'h030 + i), 8'(8'hC0 + i), 1'b1);
    chk("wr_full_after_4", int'(bus.wr_full), 1);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 11'h034;
    bus.wr_data = 8'hC4;
    wr_exp_q.push_back({11'h034, 8'hC4});
    n_ack = 0;
    n_we  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_ack += int'(bus.wr_ack);
      n_we  += int'(bus.mem_we);
      if (bus.wr_ack) bus.wr_req = 1'b0;
    end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk("guard_we_in_active", int'(n_we > 0), 1);
    chk("guard_ack5", n_ack, 1);
    bus.wr_req = 1'b0;
`else
    chk("full_ack5_held", n_ack, 0);
    chk("full_no_we_active", n_we, 0);
    chk("full_wr_full_held", int'(bus.wr_full), 1);
    bus.vga_video_on = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1;
    end
    bus.wr_req = 1'b0;
    chk("full_ack5_after_blank", got, 1);
`endif
    bus.vga_video_on = 1'b0;
    idle(10);
    chk("full_we_total", we_count - w0, 5);

    // Hazard: no forwarding from the queue; RAM updates after drain.
    bus.vga_video_on = 1'b1;
    do_write(11'h040, 8'h33, 1'b1);
    idle(3);
    do_read(11'h040, 8'h11);
    idle(4);
    bus.vga_video_on = 1'b0;
    idle(4);
    do_read(11'h040, 8'h33);
    idle(4);

    // Reset mid-operation: queued writes and in-flight read are dropped.
    bus.vga_video_on = 1'b1;
    do_write(11'h050, 8'h77, 1'b0);
    do_write(11'h051, 8'h78, 1'b0);
    w0 = we_count;
    do_read(11'h123, 8'h5A);
    rst = 1'b0;
    rd_exp_q.delete();
    #1;
    check_reset_outputs("rst_mid");
    idle(3);
    rst = 1'b1;
    bus.vga_video_on = 1'b0;
    idle(10);
    chk("post_rst_wr_full", int'(bus.wr_full), 0);
    chk("post_rst_no_we", we_count - w0, 0);

    chk("rd_scoreboard_empty", rd_exp_q.size(), 0);
    chk("wr_scoreboard_empty", wr_exp_q.size(), 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
